// File: rtl/conv_enc_k7.sv
// conv_enc_k7: rate-1/2 feed-forward convolutional encoder with optional zero-tail termination
module conv_enc_k7 #(
    parameter int           K       = 7,
    parameter logic [K-1:0] G0      = 7'o171,
    parameter logic [K-1:0] G1      = 7'o133,
    parameter bit           TAIL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] tx_pair,
    output logic       out_last,
    output logic       frame_done
);
    localparam int CW = $clog2(K);
    typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;
    state_t        state;
    logic [K-2:0]  sr;
    logic [CW-1:0] tail_cnt;
    logic          adv, in_fire, tail_step, tail_end, last_bit, load, u;
    logic [K-1:0]  w;
    assign adv       = !out_valid | out_ready;
    assign in_ready  = adv & (state != TAIL) & !rst;
    assign in_fire   = in_valid & in_ready;
    assign tail_step = adv & (state == TAIL);
    assign tail_end  = tail_step & (tail_cnt == CW'(K - 2));
    assign last_bit  = in_fire & in_last;
    assign load      = in_fire | tail_step;
    assign u         = in_fire & in_bit;
    assign w         = {u, sr};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sr         <= '0;
            tail_cnt   <= '0;
            out_valid  <= 1'b0;
            tx_pair    <= 2'b00;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_valid & out_ready & out_last;
            if (load) begin
                out_valid <= 1'b1;
                tx_pair   <= {^(w & G1), ^(w & G0)};
                out_last  <= TAIL_EN ? tail_end : last_bit;
                sr        <= (last_bit && !TAIL_EN) ? '0 : {u, sr[K-2:1]};
            end else if (adv) begin
                out_valid <= 1'b0;
            end
            if (last_bit) begin
                state <= TAIL_EN ? TAIL : IDLE;
            end else if (in_fire) begin
                state <= DATA;
            end else if (tail_end) begin
                state    <= IDLE;
                tail_cnt <= '0;
            end else if (tail_step) begin
                tail_cnt <= tail_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_conv_enc_k7.sv
// tb_conv_enc_k7: scoreboard bench for the terminated and truncating encoder variants
module tb_conv_enc_k7;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic in_valid = 1'b0, in_bit = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid, out_last, frame_done;
    logic [1:0] tx_pair;
    logic n_in_valid = 1'b0, n_in_bit = 1'b0, n_in_last = 1'b0, n_out_ready = 1'b1;
    logic n_in_ready, n_out_valid, n_out_last, n_frame_done;
    logic [1:0] n_tx_pair;

    conv_enc_k7 #(.TAIL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .tx_pair(tx_pair),
        .out_last(out_last), .frame_done(frame_done)
    );
    conv_enc_k7 #(.TAIL_EN(1'b0)) dut_n (
        .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready), .in_bit(n_in_bit),
        .in_last(n_in_last), .out_valid(n_out_valid), .out_ready(n_out_ready), .tx_pair(n_tx_pair),
        .out_last(n_out_last), .frame_done(n_frame_done)
    );

    typedef struct packed {logic [1:0] pair; logic last;} exp_t;
    exp_t q[$], qn[$];
    exp_t e_m, e_n;
    int errors = 0, checks = 0, cyc = 0;
    int first_fire = 0, last_fire = 0;
    bit rand_ready = 1'b0;
    logic fd_exp = 1'b0, stall_v = 1'b0, stall_last;
    logic [1:0] stall_pair;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic void push(input bit tail, input logic [1:0] p, input logic l);
        exp_t e;
        e.pair = p;
        e.last = l;
        if (tail) q.push_back(e); else qn.push_back(e);
    endfunction

    // Reference convolution straight from the generator definitions
    function automatic void model(input logic [1023:0] b, input int n);
        logic [5:0] s = '0;
        logic [6:0] w;
        logic u;
        for (int i = 0; i < n + 6; i++) begin
            u = (i < n) ? b[i] : 1'b0;
            w = {u, s};
            push(1'b1, {^(w & 7'o133), ^(w & 7'o171)}, i == n + 5);
            s = {u, s[5:1]};
        end
    endfunction

    task automatic drive(input logic [1023:0] b, input int n);
        bit f;
        int t;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_bit   = b[i];
            in_last  = (i == n - 1);
            t = 0;
            do begin
                @(negedge clk);
                f = in_ready;
                @(posedge clk);
                t++;
            end while (!f && t < 200);
            #1;
            if (!f) chk("in_ready_timeout", 0, 1);
            if (i == 0) first_fire = cyc;
            if (i == n - 1) last_fire = cyc;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send(input logic [1023:0] b, input int n);
        model(b, n);
        drive(b, n);
    endtask

    task automatic drive_n(input logic b, input logic l);
        n_in_valid = 1'b1;
        n_in_bit   = b;
        n_in_last  = l;
        @(negedge clk);
        chk("n_in_ready", n_in_ready, 1);
        @(posedge clk);
        #1;
        n_in_valid = 1'b0;
        n_in_last  = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst) begin
            stall_v = 1'b0;
            fd_exp  = 1'b0;
        end else begin
            if (fd_exp || frame_done) chk("frame_done", frame_done, fd_exp);
            fd_exp = 1'b0;
            if (stall_v) begin
                chk("stall_pair", tx_pair, stall_pair);
                chk("stall_last", out_last, stall_last);
            end
            stall_v    = out_valid & !out_ready;
            stall_pair = tx_pair;
            stall_last = out_last;
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("unexpected_pair", 1, 0);
                else begin
                    e_m = q.pop_front();
                    chk("pair", tx_pair, e_m.pair);
                    chk("last", out_last, e_m.last);
                end
                fd_exp = out_last;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && n_out_valid) begin
            if (qn.size() == 0) chk("n_unexpected_pair", 1, 0);
            else begin
                e_n = qn.pop_front();
                chk("n_pair", n_tx_pair, e_n.pair);
                chk("n_last", n_out_last, e_n.last);
            end
        end
    end

    initial begin
        logic [1023:0] bits;
        int prev_last, t;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_tx_pair", tx_pair, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_frame_done", frame_done, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        // Impulse response, hand-derived
        bits = '0;
        bits[0] = 1'b1;
        push(1, 2'b11, 0); push(1, 2'b01, 0); push(1, 2'b11, 0); push(1, 2'b11, 0);
        push(1, 2'b00, 0); push(1, 2'b10, 0); push(1, 2'b11, 1);
        drive(bits, 1);
        repeat (10) @(posedge clk);
        #1;
        // All-zero 10-bit frame: 16 zero pairs and six tail cycles with in_ready low
        bits = '0;
        for (int i = 0; i < 16; i++) push(1, 2'b00, i == 15);
        drive(bits, 10);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("tail_in_ready", in_ready, 0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("post_tail_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        // Two random 1000-bit frames back to back with no gap
        for (int i = 0; i < 1000; i++) bits[i] = 1'($urandom_range(0, 1));
        send(bits, 1000);
        prev_last = last_fire;
        for (int i = 0; i < 1000; i++) bits[i] = 1'($urandom_range(0, 1));
        send(bits, 1000);
        chk("b2b_gap", first_fire - prev_last, 7);
        // Random backpressure through data and tail
        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) bits[i] = 1'($urandom_range(0, 1));
        send(bits, 200);
        bits = '0;
        bits[0] = 1'b1;
        bits[2] = 1'b1;
        send(bits, 5);
        t = 0;
        while (q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        rand_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset during the third tail cycle aborts the frame
        bits = '0;
        bits[0] = 1'b1;
        send(bits, 1);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midtail_out_valid", out_valid, 0);
        chk("midtail_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        q.delete();
        rst = 1'b0;
        push(1, 2'b11, 0); push(1, 2'b01, 0); push(1, 2'b11, 0); push(1, 2'b11, 0);
        push(1, 2'b00, 0); push(1, 2'b10, 0); push(1, 2'b11, 1);
        drive(bits, 1);
        // Truncating variant: state cleared after in_last
        push(0, 2'b11, 0); push(0, 2'b01, 0); push(0, 2'b00, 1);
        drive_n(1'b1, 1'b0);
        drive_n(1'b0, 1'b0);
        drive_n(1'b1, 1'b1);
        push(0, 2'b11, 1);
        drive_n(1'b1, 1'b1);
        t = 0;
        while ((q.size() != 0 || qn.size() != 0) && t < 200) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain_q", q.size(), 0);
        chk("drain_qn", qn.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/conv_enc_k7.md
Name: conv_enc_k7

Overview:
- Rate-1/2 feed-forward convolutional encoder; transmit-side counterpart of the Viterbi decoder's branch-metric/ACS path.
- Accepts a serial bit stream with valid/ready and framing, and emits one 2-bit coded symbol per input bit.
- Optionally appends K-1 zero tail bits per frame so each trellis starts and ends in state 0, as the 64-state decoder requires.
- The output pair uses the same bit layout as the decoder's received pair: bit0 = G0 output, bit1 = G1 output.

Parameters:
- K, 7, constraint length. The state register is K-1 bits, giving 2^(K-1) = 64 states.
- G0, 7'o171, generator polynomial for tx_pair[0]. Bit K-1 taps the current input bit.
- G1, 7'o133, generator polynomial for tx_pair[1]. Same tap convention as G0.
- TAIL_EN, 1, 1 = append K-1 zero tail bits after in_last; 0 = truncate and clear state after in_last.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  in_bit is valid
- in_ready  out  1  encoder accepts in_bit this cycle
- in_bit  in  1  information bit
- in_last  in  1  marks the final information bit of a frame
- out_valid  out  1  tx_pair is valid
- out_ready  in  1  downstream accepts tx_pair
- tx_pair  out  2  {G1 parity, G0 parity}
- out_last  out  1  marks the final coded pair of a frame
- frame_done  out  1  one-cycle pulse when the out_last pair is accepted downstream

Behaviour:
- Reset (async, rst=1): state=IDLE; sr=0; tail_cnt=0; out_valid=0; tx_pair=0; out_last=0; frame_done=0; in_ready=0 while rst is high.
- Encoding:
  - Window w = {u, sr[K-2:0]}; sr[K-2] is the most recent past bit.
  - tx_pair[0] = ^(w & G0); tx_pair[1] = ^(w & G1).
  - sr_next = {u, sr[K-2:1]}.
- Output register (single stage):
  - adv = !out_valid | out_ready.
  - On each load: out_valid=1 and tx_pair/out_last are updated.
  - If adv=1 and nothing loads: out_valid=0.
  - Holding rule: while out_valid=1 and out_ready=0, tx_pair and out_last stay stable.
- Input handshake:
  - in_ready = adv & (state != TAIL).
  - in_fire = in_valid & in_ready.
  - Latency from in_fire to out_valid is exactly 1 cycle. Full throughput: 1 pair per cycle when out_ready=1.
- State machine:
  - IDLE: sr=0. On in_fire, encode u=in_bit. If in_last=0, go to DATA. If in_last=1, go to TAIL (TAIL_EN=1) or stay in IDLE with sr cleared (TAIL_EN=0).
  - DATA: on in_fire, encode u=in_bit. On in_fire with in_last=1, same exit as in IDLE. With no in_fire, hold.
  - TAIL (TAIL_EN=1 only): each cycle with adv=1, encode u=0 and increment tail_cnt. The pair with tail_cnt=K-2 loads with out_last=1, after which tail_cnt=0 and state=IDLE. sr is then 0 by construction.
- out_last:
  - TAIL_EN=1: set only on the final tail pair. The pair for the data bit carrying in_last has out_last=0.
  - TAIL_EN=0: set on the pair for the in_last bit.
- Frame size: with TAIL_EN=1, a frame of N information bits produces exactly N+K-1 pairs.
- frame_done: registered pulse in the cycle after out_valid & out_ready & out_last.
- Backpressure: with out_ready=0, no state, sr, or tail_cnt change occurs and nothing is dropped or duplicated.
- Boundary cases:
  - Single-bit frame (in_last on the first bit): legal; goes directly to TAIL.
  - A new frame's first bit can be accepted in the cycle after the final tail pair loads, giving back-to-back frames with no idle gap.
  - rst asserted mid-frame or mid-tail immediately aborts. The pending output is discarded (out_valid=0) and no frame_done is issued.
- in_valid must not be asserted in the TAIL state; in_ready=0 there, so such data is simply not consumed.

Test Plan:
- Impulse: frame with a single bit 1 (in_last=1), out_ready=1 -> 7 pairs 2'b11,01,11,11,00,10,11; out_last only on the 7th pair; frame_done one cycle later.
- All-zero frame of 10 bits -> 16 pairs, all 2'b00; out_last on pair 16; in_ready=0 for the 6 tail cycles.
- Random 1000-bit frames, back-to-back, out_ready=1 -> output matches the golden model and a zero-gap frame boundary is observed. Decoding through the team's Viterbi decoder returns the original bits with zero errors.
- Random out_ready toggling, 50% duty, during data and tail -> tx_pair stable while stalled; pair count = N+6; sequence identical to the no-stall run.
- rst pulsed during the 3rd tail cycle -> out_valid=0 and in_ready=0 while rst is high. The next frame's impulse reproduces the impulse sequence exactly (sr cleared).
- TAIL_EN=0, frame 1,0,1 with in_last on the 3rd bit -> pairs 11,01,00, out_last on the 3rd. The next frame bit 1 gives 11, confirming sr was cleared.
